// File: rtl/disp_scan4.sv
// 4-digit multiplexed 7-segment front end: binary-to-BCD by shift-add-3,
// committed digits scanned one slot at a time with dead time and leading-zero blanking.

module disp_scan4_add3 (
    input  logic [3:0] nib,
    output logic [3:0] adj
);
    assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

module disp_scan4 #(
    parameter int SCAN_BITS  = 14,
    parameter int DEAD       = 8,
    parameter int BLANK_LEAD = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] in_value,
    input  logic [3:0]  in_dp,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  seg_digit,
    output logic        seg_dot,
    output logic [3:0]  digit_en,
    output logic        ovf
);
    localparam int NUM_LANES = 5;
    localparam logic [SCAN_BITS-1:0] DEAD_W = SCAN_BITS'(DEAD);

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
    } req_t;

    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

    state_t                     state_q, state_d;
    logic [15:0]                shift_q, shift_d;
    logic [NUM_LANES-1:0][3:0]  bcd_q, bcd_d, bcd_adj;
    logic [3:0]                 step_q, step_d;
    logic [3:0]                 dp_lat_q, dp_lat_d;
    logic                       accept, commit;
    req_t                       req;

    logic [3:0][3:0]            dig_q;
    logic [3:0]                 dot_q;
    logic                       ovf_q;
    logic [3:0]                 blank;
    logic                       lead;

    logic [SCAN_BITS-1:0]       slot_q;
    logic [1:0]                 idx_q;

    assign req      = '{value: in_value, dp: in_dp};
    assign in_ready = (state_q != CONV);
    assign accept   = in_valid && in_ready;

    // One add-3 corrector per BCD nibble, including the ten-thousands overflow nibble.
    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            disp_scan4_add3 u_add3 (.nib(bcd_q[g]), .adj(bcd_adj[g]));
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            step_q   <= '0;
            dp_lat_q <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            step_q   <= step_d;
            dp_lat_q <= dp_lat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        step_d   = step_q;
        dp_lat_d = dp_lat_q;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d  = req.value;
                    bcd_d    = '0;
                    step_d   = 4'd15;
                    dp_lat_d = req.dp;
                    state_d  = CONV;
                end
            end
            CONV: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                step_d = step_q - 4'd1;
                if (step_q == 4'd0) state_d = DONE;
            end
            DONE: begin
                commit  = 1'b1;
                state_d = IDLE;
                // Accepting here keeps the throughput at one value per 17 cycles.
                if (accept) begin
                    shift_d  = req.value;
                    bcd_d    = '0;
                    step_d   = 4'd15;
                    dp_lat_d = req.dp;
                    state_d  = CONV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dig_q <= '0;
            dot_q <= '0;
            ovf_q <= 1'b0;
        end else if (commit) begin
            if (bcd_q[4] != 4'd0) begin
                dig_q <= {4{4'd9}};
                dot_q <= 4'b1111;
                ovf_q <= 1'b1;
            end else begin
                for (int k = 0; k < 4; k++) dig_q[k] <= bcd_q[3-k];
                dot_q <= dp_lat_q;
                ovf_q <= 1'b0;
            end
        end
    end

    // Digit 0 is the thousands; the units digit is never blanked.
    always_comb begin
        blank = '0;
        lead  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lead     = lead & (dig_q[k] == 4'd0);
            blank[k] = (BLANK_LEAD != 0) && lead && !dot_q[k] && !ovf_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            slot_q <= '0;
            idx_q  <= '0;
        end else begin
            slot_q <= slot_q + 1'b1;
            if (&slot_q) idx_q <= idx_q + 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            seg_digit <= '0;
            seg_dot   <= 1'b0;
            digit_en  <= '0;
        end else begin
            seg_digit <= dig_q[idx_q];
            seg_dot   <= dot_q[idx_q];
            digit_en  <= (slot_q < DEAD_W || blank[idx_q]) ? 4'd0 : (4'd1 << idx_q);
        end
    end

    assign ovf = ovf_q;

endmodule
